mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_pkg.sv | 16 +
 rtl/mdu_step.sv | 32 +++
 rtl/mult_div_unit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings and FSM states.
package mult_div_pkg;

    localparam int   OP_DIV_BIT    = 0;
    localparam int   OP_SIGNED_BIT = 1;
    localparam logic OP_MULT       = 1'b0;
    localparam logic OP_DIV        = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div_i,
    input  logic [2*WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0]   operand_i,
    output logic [2*WIDTH:0]   acc_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted_rem;
    logic [WIDTH+1:0] diff;

    // Multiply layout {carry, hi, lo}; divide layout {rem[W:0], quotient[W-1:0]}.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        acc_o       = acc_i;
        sum         = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, (acc_i[0] ? operand_i : '0)};
        shifted_rem = acc_i[2*WIDTH-1:WIDTH-1];
        diff        = {1'b0, shifted_rem} - {2'b00, operand_i};
        if (is_div_i) begin
            if (diff[WIDTH+1])
                acc_o = {shifted_rem, acc_i[WIDTH-2:0], 1'b0};
            else
                acc_o = {diff[WIDTH:0], acc_i[WIDTH-2:0], 1'b1};
        end else begin
            acc_o = {1'b0, sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle signed/unsigned multiply-divide unit feeding the CPU HI/LO registers.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int AW = 2 * WIDTH + 1;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q;
    logic [AW-1:0]    acc_q;
    logic [AW-1:0]    acc_d;
    logic [WIDTH-1:0] opnd_q;
    logic [CW-1:0]    cnt_q;
    logic             is_div_q;
    logic             neg_lo_q;
    logic             neg_hi_q;
    logic             dz_pend_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;
    logic             div_zero_q;

    logic             a_neg;
    logic             b_neg;
    logic             op_is_div;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i  (is_div_q),
        .acc_i     (acc_q),
        .operand_i (opnd_q),
        .acc_o     (acc_d)
    );

    // Iterations run on magnitudes; the most-negative value's magnitude still fits unsigned.
    always_comb begin
        op_is_div = (op[OP_DIV_BIT] == OP_DIV);
        a_neg     = op[OP_SIGNED_BIT] & a[WIDTH-1];
        b_neg     = op[OP_SIGNED_BIT] & b[WIDTH-1];
        a_mag     = a_neg ? (~a + ONE_W) : a;
        b_mag     = b_neg ? (~b + ONE_W) : b;

        prod_fix  = neg_lo_q ? (~acc_q[2*WIDTH-1:0] + ONE_2W) : acc_q[2*WIDTH-1:0];
        quo_fix   = neg_lo_q ? (~acc_q[WIDTH-1:0] + ONE_W) : acc_q[WIDTH-1:0];
        rem_fix   = neg_hi_q ? (~acc_q[2*WIDTH-1:WIDTH] + ONE_W) : acc_q[2*WIDTH-1:WIDTH];
        hi_d      = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        lo_d      = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!reset) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            opnd_q     <= '0;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            dz_pend_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        is_div_q   <= op_is_div;
                        acc_q      <= {{(WIDTH+1){1'b0}}, (op_is_div ? a_mag : b_mag)};
                        opnd_q     <= op_is_div ? b_mag : a_mag;
                        neg_lo_q   <= a_neg ^ b_neg;
                        neg_hi_q   <= op_is_div ? a_neg : (a_neg ^ b_neg);
                        dz_pend_q  <= op_is_div && (b == '0);
                        div_zero_q <= 1'b0;
                        cnt_q      <= CW'(WIDTH);
                        busy_q     <= 1'b1;
                        state_q    <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    // A zero divisor skips the iterations and leaves hi/lo untouched.
                    if (dz_pend_q) begin
                        dz_pend_q  <= 1'b0;
                        div_zero_q <= 1'b1;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= ST_DONE;
                    end else if (cnt_q != '0) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;

endmodule
